// File: rtl/pong_pkg.sv
// Shared constants, game-state type and small geometry helpers for the pong block.
package pong_pkg;

    localparam logic [9:0] H_ACT_START = 10'd48;
    localparam logic [9:0] V_ACT_START = 10'd33;
    localparam logic [9:0] TICK_SX     = 10'd0;
    localparam logic [9:0] TICK_SY     = 10'd513;

    localparam logic [9:0] PAD_W       = 10'd8;
    localparam logic [9:0] PAD_H       = 10'd48;
    localparam logic [9:0] PAD_L_X     = 10'd16;
    localparam logic [9:0] PAD_R_X     = 10'd616;
    localparam logic [9:0] PAD_Y_MAX   = 10'd432;
    localparam logic [9:0] PAD_Y_INIT  = 10'd216;
    localparam logic [9:0] PAD_STEP    = 10'd4;

    localparam logic [9:0] BALL_SIZE   = 10'd8;
    localparam logic [9:0] BALL_SPEED  = 10'd2;
    localparam logic [9:0] BALL_X0     = 10'd316;
    localparam logic [9:0] BALL_Y0     = 10'd236;
    localparam logic [9:0] BALL_Y_MAX  = 10'd472;
    localparam logic [9:0] BALL_HIT_L  = 10'd24;
    localparam logic [9:0] BALL_HIT_R  = 10'd608;
    localparam logic [9:0] BALL_MISS_L = 10'd2;
    localparam logic [9:0] BALL_MISS_R = 10'd630;
    localparam logic [5:0] MISS_HOLD   = 6'd59;

    localparam logic [9:0] NET_X0      = 10'd319;
    localparam logic [9:0] NET_X1      = 10'd320;

    localparam logic [11:0] COL_BALL   = 12'hFFF;
    localparam logic [11:0] COL_PAD    = 12'h0F0;
    localparam logic [11:0] COL_NET    = 12'h888;
    localparam logic [11:0] COL_BG     = 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_MISS = 2'd2
    } state_t;

    // Saturating paddle step; both buttons together cancel out.
    function automatic logic [9:0] pad_move(input logic [9:0] y, input logic up, input logic dn);
        logic [9:0] res;
        res = y;
        if (up && !dn)
            res = (y < PAD_STEP) ? 10'd0 : y - PAD_STEP;
        else if (dn && !up)
            res = (y > PAD_Y_MAX - PAD_STEP) ? PAD_Y_MAX : y + PAD_STEP;
        return res;
    endfunction

    function automatic logic ball_overlaps(input logic [9:0] by, input logic [9:0] py);
        return (({1'b0, by} + 11'(BALL_SIZE)) > {1'b0, py}) &&
               ({1'b0, by} < ({1'b0, py} + 11'(PAD_H)));
    endfunction

endpackage

// File: rtl/pong_physics.sv
// Game state: FSM, ball motion, paddles and miss pulses, advanced once per frame tick.
// Optional PONG_AUTO_PADDLE_EN makes the right paddle chase the ball instead of its buttons.
module pong_physics
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       i_tick,
    input  logic [1:0] i_btn_up,
    input  logic [1:0] i_btn_dn,
    output logic [9:0] o_ball_x,
    output logic [9:0] o_ball_y,
    output logic [9:0] o_pad_l_y,
    output logic [9:0] o_pad_r_y,
    output logic       o_miss_l,
    output logic       o_miss_r
);

    state_t     r_state, w_state_next;
    logic [9:0] r_bx, r_by, w_bx_next, w_by_next;
    logic       r_dx, r_dy, w_dx_next, w_dy_next;   // dx=1 right, dy=1 down
    logic [5:0] r_cnt, w_cnt_next;
    logic       r_serve, w_serve_next;
    logic       r_miss_l, r_miss_r, w_miss_l, w_miss_r;
    logic [9:0] w_pad_y [2];
    logic       w_ov_l, w_ov_r, w_hit_l, w_hit_r;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pad
            logic [9:0] r_y;
            logic       w_up, w_dn;
`ifdef PONG_AUTO_PADDLE_EN
            if (gi == 1) begin : g_auto
                logic signed [11:0] w_target, w_cur;
                assign w_target = $signed({2'b00, r_by}) - 12'sd20;
                assign w_cur    = $signed({2'b00, r_y});
                assign w_up     = w_cur > (w_target + 12'sd4);
                assign w_dn     = (w_cur + 12'sd4) < w_target;
            end else begin : g_btn
                assign w_up = i_btn_up[gi];
                assign w_dn = i_btn_dn[gi];
            end
`else
            assign w_up = i_btn_up[gi];
            assign w_dn = i_btn_dn[gi];
`endif
            always_ff @(posedge clk) begin
                if (srst)
                    r_y <= PAD_Y_INIT;
                else if (i_tick)
                    r_y <= pad_move(r_y, w_up, w_dn);
            end
            assign w_pad_y[gi] = r_y;
        end
    endgenerate

    // Collisions see the paddles as they were before this tick's move.
    assign w_ov_l  = ball_overlaps(r_by, w_pad_y[0]);
    assign w_ov_r  = ball_overlaps(r_by, w_pad_y[1]);
    // Paddle faces are tested against the position the ball is about to move to.
    assign w_hit_l = !r_dx && (r_bx <= BALL_HIT_L + BALL_SPEED) && w_ov_l;
    assign w_hit_r =  r_dx && (r_bx >= BALL_HIT_R - BALL_SPEED) && w_ov_r;

    always_comb begin
        w_state_next = r_state;
        w_bx_next    = r_bx;
        w_by_next    = r_by;
        w_dx_next    = r_dx;
        w_dy_next    = r_dy;
        w_cnt_next   = r_cnt;
        w_serve_next = r_serve;
        w_miss_l     = 1'b0;
        w_miss_r     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|{i_btn_up, i_btn_dn}) begin
                    w_state_next = ST_PLAY;
                    w_dx_next    = 1'b1;
                    w_dy_next    = 1'b1;
                end
            end
            ST_PLAY: begin
                if (!r_dx && !w_hit_l && r_bx <= BALL_MISS_L) begin
                    w_state_next = ST_MISS;
                    w_miss_l     = 1'b1;
                    w_serve_next = 1'b0;
                    w_cnt_next   = MISS_HOLD;
                end else if (r_dx && !w_hit_r && r_bx >= BALL_MISS_R) begin
                    w_state_next = ST_MISS;
                    w_miss_r     = 1'b1;
                    w_serve_next = 1'b1;
                    w_cnt_next   = MISS_HOLD;
                end else begin
                    if (w_hit_l) begin
                        w_bx_next = BALL_HIT_L;
                        w_dx_next = 1'b1;
                    end else if (w_hit_r) begin
                        w_bx_next = BALL_HIT_R;
                        w_dx_next = 1'b0;
                    end else begin
                        w_bx_next = r_dx ? r_bx + BALL_SPEED : r_bx - BALL_SPEED;
                    end
                    if (!r_dy && r_by <= BALL_SPEED) begin
                        w_by_next = 10'd0;
                        w_dy_next = 1'b1;
                    end else if (r_dy && r_by >= BALL_Y_MAX - BALL_SPEED) begin
                        w_by_next = BALL_Y_MAX;
                        w_dy_next = 1'b0;
                    end else begin
                        w_by_next = r_dy ? r_by + BALL_SPEED : r_by - BALL_SPEED;
                    end
                end
            end
            ST_MISS: begin
                if (r_cnt == 6'd0) begin
                    w_state_next = ST_PLAY;
                    w_bx_next    = BALL_X0;
                    w_by_next    = BALL_Y0;
                    w_dx_next    = r_serve;
                    w_dy_next    = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 6'd1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state  <= ST_IDLE;
            r_bx     <= BALL_X0;
            r_by     <= BALL_Y0;
            r_dx     <= 1'b1;
            r_dy     <= 1'b1;
            r_cnt    <= 6'd0;
            r_serve  <= 1'b1;
            r_miss_l <= 1'b0;
            r_miss_r <= 1'b0;
        end else begin
            r_miss_l <= i_tick & w_miss_l;
            r_miss_r <= i_tick & w_miss_r;
            if (i_tick) begin
                r_state <= w_state_next;
                r_bx    <= w_bx_next;
                r_by    <= w_by_next;
                r_dx    <= w_dx_next;
                r_dy    <= w_dy_next;
                r_cnt   <= w_cnt_next;
                r_serve <= w_serve_next;
            end
        end
    end

    assign o_ball_x  = r_bx;
    assign o_ball_y  = r_by;
    assign o_pad_l_y = w_pad_y[0];
    assign o_pad_r_y = w_pad_y[1];
    assign o_miss_l  = r_miss_l;
    assign o_miss_r  = r_miss_r;

endmodule

// File: rtl/pong_render.sv
// Pong top: frame-tick detection, pixel drawing and one-cycle alignment of video strobes.
// Build option PONG_AUTO_PADDLE_EN is handled inside pong_physics.
module pong_render
    import pong_pkg::*;
(
    input  logic       pix_clk,
    input  logic       rst_pix,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [1:0] btn_up,
    input  logic [1:0] btn_dn,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       de_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       miss_l,
    output logic       miss_r
);

    logic        w_tick;
    logic [9:0]  w_px, w_py;
    logic [9:0]  w_ball_x, w_ball_y;
    logic [9:0]  w_pad_y [2];
    logic        w_in_ball, w_in_net;
    logic [1:0]  w_in_pad;
    logic [11:0] w_rgb;
    logic [11:0] r_rgb;
    logic        r_de, r_hsync, r_vsync;

    assign w_tick = (sx == TICK_SX) && (sy == TICK_SY);
    assign w_px   = sx - H_ACT_START;
    assign w_py   = sy - V_ACT_START;

    pong_physics u_physics (
        .clk       (pix_clk),
        .srst      (rst_pix),
        .i_tick    (w_tick),
        .i_btn_up  (btn_up),
        .i_btn_dn  (btn_dn),
        .o_ball_x  (w_ball_x),
        .o_ball_y  (w_ball_y),
        .o_pad_l_y (w_pad_y[0]),
        .o_pad_r_y (w_pad_y[1]),
        .o_miss_l  (miss_l),
        .o_miss_r  (miss_r)
    );

    assign w_in_ball = ({1'b0, w_px} >= {1'b0, w_ball_x}) &&
                       ({1'b0, w_px} <  {1'b0, w_ball_x} + 11'(BALL_SIZE)) &&
                       ({1'b0, w_py} >= {1'b0, w_ball_y}) &&
                       ({1'b0, w_py} <  {1'b0, w_ball_y} + 11'(BALL_SIZE));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pad_draw
            localparam logic [9:0] X0 = (gi == 0) ? PAD_L_X : PAD_R_X;
            assign w_in_pad[gi] = (w_px >= X0) && (w_px < X0 + PAD_W) &&
                                  ({1'b0, w_py} >= {1'b0, w_pad_y[gi]}) &&
                                  ({1'b0, w_py} <  {1'b0, w_pad_y[gi]} + 11'(PAD_H));
        end
    endgenerate

    // Dashed centre line: two pixels wide, 16 rows on / 16 rows off.
    assign w_in_net = ((w_px == NET_X0) || (w_px == NET_X1)) && !w_py[4];

    always_comb begin
        w_rgb = COL_BG;
        if (de) begin
            if (w_in_ball)
                w_rgb = COL_BALL;
            else if (|w_in_pad)
                w_rgb = COL_PAD;
            else if (w_in_net)
                w_rgb = COL_NET;
        end
    end

    always_ff @(posedge pix_clk) begin
        if (rst_pix) begin
            r_rgb   <= COL_BG;
            r_de    <= 1'b0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_rgb   <= w_rgb;
            r_de    <= de;
            r_hsync <= hsync;
            r_vsync <= vsync;
        end
    end

    assign r       = r_rgb[11:8];
    assign g       = r_rgb[7:4];
    assign b       = r_rgb[3:0];
    assign de_o    = r_de;
    assign hsync_o = r_hsync;
    assign vsync_o = r_vsync;

endmodule

// File: tb/tb_pong_render.sv
// Directed bench for pong_render: a behavioural game model feeds a scoreboard queue of expected outputs.
module tb_pong_render;

    logic       pix_clk;
    logic       rst_pix;
    logic [9:0] sx, sy;
    logic       de, hsync, vsync;
    logic [1:0] btn_up, btn_dn;
    logic [3:0] r, g, b;
    logic       de_o, hsync_o, vsync_o, miss_l, miss_r;

    pong_render dut (
        .pix_clk (pix_clk), .rst_pix (rst_pix),
        .sx (sx), .sy (sy), .de (de), .hsync (hsync), .vsync (vsync),
        .btn_up (btn_up), .btn_dn (btn_dn),
        .r (r), .g (g), .b (b),
        .de_o (de_o), .hsync_o (hsync_o), .vsync_o (vsync_o),
        .miss_l (miss_l), .miss_r (miss_r)
    );

    initial pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    typedef struct packed {
        logic [11:0] rgb;
        logic [2:0]  sync;
        logic [1:0]  miss;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   dut_ml = 0, dut_mr = 0;
    int   mod_ml = 0, mod_mr = 0;

    // Game model: state 0 idle, 1 play, 2 miss.
    int m_state, m_bx, m_by, m_dx, m_dy, m_cnt, m_serve, m_pl, m_pr;

    task automatic model_reset();
        m_state = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
        m_cnt = 0; m_serve = 1; m_pl = 216; m_pr = 216;
    endtask

    function automatic int pad_step(input int y, input logic up, input logic dn);
        if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > 432) ? 432 : y + 4;
        return y;
    endfunction

    function automatic logic [11:0] exp_rgb(input int x, input int y, input logic de_i);
        int px, py;
        if (!de_i) return 12'h000;
        px = x - 48;
        py = y - 33;
        if (px >= m_bx && px < m_bx + 8 && py >= m_by && py < m_by + 8) return 12'hFFF;
        if (px >= 16 && px <= 23 && py >= m_pl && py < m_pl + 48) return 12'h0F0;
        if (px >= 616 && px <= 623 && py >= m_pr && py < m_pr + 48) return 12'h0F0;
        if ((px == 319 || px == 320) && (py % 32) < 16) return 12'h888;
        return 12'h000;
    endfunction

    task automatic model_tick(input logic [1:0] up, input logic [1:0] dn,
                              output logic ml, output logic mr);
        int  npl, npr, nx;
        logic ovl, ovr, hitl, hitr;
        ml = 1'b0;
        mr = 1'b0;
        npl = pad_step(m_pl, up[0], dn[0]);
`ifdef PONG_AUTO_PADDLE_EN
        npr = m_pr;
        if (m_pr > m_by - 20 + 4)      npr = (m_pr - 4 < 0) ? 0 : m_pr - 4;
        else if (m_pr + 4 < m_by - 20) npr = (m_pr + 4 > 432) ? 432 : m_pr + 4;
`else
        npr = pad_step(m_pr, up[1], dn[1]);
`endif
        if (m_state == 0) begin
            if (up != 2'b00 || dn != 2'b00) begin
                m_state = 1; m_dx = 1; m_dy = 1;
            end
        end else if (m_state == 1) begin
            ovl  = (m_by + 8 > m_pl) && (m_by < m_pl + 48);
            ovr  = (m_by + 8 > m_pr) && (m_by < m_pr + 48);
            nx   = (m_dx == 1) ? m_bx + 2 : m_bx - 2;
            hitl = (m_dx == 0) && (nx <= 24) && ovl;
            hitr = (m_dx == 1) && (nx >= 608) && ovr;
            if (m_dx == 0 && !hitl && m_bx <= 2) begin
                m_state = 2; m_cnt = 59; m_serve = 0; ml = 1'b1;
            end else if (m_dx == 1 && !hitr && m_bx >= 630) begin
                m_state = 2; m_cnt = 59; m_serve = 1; mr = 1'b1;
            end else begin
                if (hitl)      begin m_bx = 24;  m_dx = 1; end
                else if (hitr) begin m_bx = 608; m_dx = 0; end
                else           m_bx = nx;
                if (m_dy == 0 && m_by <= 2)        begin m_by = 0;   m_dy = 1; end
                else if (m_dy == 1 && m_by >= 470) begin m_by = 472; m_dy = 0; end
                else m_by = (m_dy == 1) ? m_by + 2 : m_by - 2;
            end
        end else begin
            if (m_cnt == 0) begin
                m_state = 1; m_bx = 316; m_by = 236; m_dx = m_serve; m_dy = 1;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        m_pl = npl;
        m_pr = npr;
        if (ml) mod_ml++;
        if (mr) mod_mr++;
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        if (miss_l === 1'b1) dut_ml++;
        if (miss_r === 1'b1) dut_mr++;
        checks++;
        assert ({r, g, b} === e.rgb) else begin
            errors++;
            $error("FAIL rgb: got %h expected %h (ball %0d,%0d)", {r, g, b}, e.rgb, m_bx, m_by);
        end
        checks++;
        assert ({de_o, hsync_o, vsync_o} === e.sync) else begin
            errors++;
            $error("FAIL strobes de/hs/vs: got %b expected %b", {de_o, hsync_o, vsync_o}, e.sync);
        end
        checks++;
        assert ({miss_l, miss_r} === e.miss) else begin
            errors++;
            $error("FAIL miss l/r: got %b expected %b", {miss_l, miss_r}, e.miss);
        end
    endtask

    task automatic cyc(input int isx, input int isy, input logic ide, input logic ihs,
                       input logic ivs, input logic [1:0] iup, input logic [1:0] idn);
        exp_t e;
        logic ml, mr;
        rst_pix = 1'b0;
        sx = 10'(isx); sy = 10'(isy); de = ide; hsync = ihs; vsync = ivs;
        btn_up = iup; btn_dn = idn;
        e.rgb  = exp_rgb(isx, isy, ide);
        e.sync = {ide, ihs, ivs};
        ml = 1'b0;
        mr = 1'b0;
        if (isx == 0 && isy == 513) model_tick(iup, idn, ml, mr);
        e.miss = {ml, mr};
        sb.push_back(e);
        @(posedge pix_clk);
        #1;
        check_out();
    endtask

    task automatic rst_cycle(input int isx, input int isy, input logic [1:0] iup, input logic [1:0] idn);
        exp_t e;
        rst_pix = 1'b1;
        sx = 10'(isx); sy = 10'(isy); de = 1'b1; hsync = 1'b0; vsync = 1'b0;
        btn_up = iup; btn_dn = idn;
        model_reset();
        e.rgb = 12'h000; e.sync = 3'b011; e.miss = 2'b00;
        sb.push_back(e);
        @(posedge pix_clk);
        #1;
        check_out();
    endtask

    task automatic probe(input int px, input int py);
        cyc(px + 48, py + 33, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b00, 2'b00);
    endtask

    // One frame tick followed by probes at the ball and paddle edges.
    task automatic tick(input logic [1:0] up, input logic [1:0] dn);
        cyc(0, 513, 1'b0, 1'b1, 1'b1, up, dn);
        probe(m_bx + 7, m_by + 7);
        probe(m_bx + 8, m_by + 8);
        probe(16, m_pl);
        probe(20, m_pl + 47);
        probe(616, m_pr);
        probe(623, m_pr + 48);
    endtask

    task automatic track_tick(input logic left_on);
        logic [1:0] up, dn;
        up = 2'b00;
        dn = 2'b00;
        if (left_on) begin
            if (m_pl + 20 > m_by)      up[0] = 1'b1;
            else if (m_pl + 28 < m_by) dn[0] = 1'b1;
        end else begin
            up[0] = 1'b1;
        end
        if (m_pr + 20 > m_by)      up[1] = 1'b1;
        else if (m_pr + 28 < m_by) dn[1] = 1'b1;
        tick(up, dn);
    endtask

    initial begin
        rst_pix = 1'b1; sx = '0; sy = '0; de = 1'b0; hsync = 1'b1; vsync = 1'b1;
        btn_up = 2'b00; btn_dn = 2'b00;
        model_reset();
        repeat (3) rst_cycle(0, 0, 2'b00, 2'b00);

        // Idle ball and dashed net around the screen centre.
        for (int y = 228; y < 252; y++)
            for (int x = 304; x < 336; x++)
                probe(x, y);
        cyc(48 + 318, 33 + 238, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        cyc(48 + 318, 33 + 238, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        cyc(48, 33, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        repeat (3) tick(2'b00, 2'b00);

        // Left paddle down to the floor (also serves), then both buttons hold.
        repeat (60) tick(2'b00, 2'b01);
        repeat (5)  tick(2'b01, 2'b01);

        // Right paddle parked at the top so the ball gets past it.
        repeat (240) tick(2'b10, 2'b00);

        // Both paddles follow the ball, then the left player gives up.
        repeat (500) track_tick(1'b1);
        repeat (400) track_tick(1'b0);

        // Reset landing on a tick cycle with buttons pressed.
        rst_cycle(0, 513, 2'b11, 2'b00);
        tick(2'b00, 2'b00);
        probe(316, 236);
        probe(315, 236);

        checks++;
        assert (dut_ml === mod_ml) else begin
            errors++;
            $error("FAIL miss_l pulse count: got %0d expected %0d", dut_ml, mod_ml);
        end
        checks++;
        assert (dut_mr === mod_mr) else begin
            errors++;
            $error("FAIL miss_r pulse count: got %0d expected %0d", dut_mr, mod_mr);
        end
`ifdef PONG_AUTO_PADDLE_EN
        checks++;
        assert (dut_mr === 0) else begin
            errors++;
            $error("FAIL auto paddle miss_r count: got %0d expected 0", dut_mr);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
